prg_inject: RTL and testbench

- Downstream consumer of the SD-card loader's ioctl byte stream while a PRG image is loading.
- Strips the 2-byte little-endian load-address header and writes each payload byte into VIC-20 main RAM through a single-port request/acknowledge RAM port.
- Back-pressures the loader via ioctl_wait.
- After the last byte, optionally patches the BASIC end-of-program pointers, then pulses prg_done.

---
 rtl/prg_inject_pkg.sv | 32 +++
 rtl/prg_skid_fifo.sv | 57 +++++
 rtl/prg_inject.sv | 183 ++++++++++++++++++
 tb/tb_prg_inject.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prg_inject_pkg.sv
// Shared types and constants for the PRG image injector.
// The pointer-patch table lists the zero-page targets in the order they are written.
package prg_inject_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    PTR,
    DONE
  } state_t;

  localparam int HDR_BYTES = 2;

  localparam logic [7:0] PTR_BASE_DEF = 8'h2D;
  localparam logic [7:0] EAL_ADDR_DEF = 8'hAE;

  typedef logic [7:0][7:0] ptr_tbl_t;

  // Three BASIC pointer pairs, then the KERNAL end-address pair; even entries take lo, odd take hi.
  function automatic ptr_tbl_t ptr_table(input logic [7:0] ptr_base, input logic [7:0] eal_addr);
    ptr_tbl_t t;
    for (int i = 0; i < 6; i++) t[i] = ptr_base + 8'(i);
    t[6] = eal_addr;
    t[7] = eal_addr + 8'd1;
    return t;
  endfunction

  localparam ptr_tbl_t PTR_TABLE = ptr_table(PTR_BASE_DEF, EAL_ADDR_DEF);

endpackage

// File: rtl/prg_skid_fifo.sv
// Small synchronous FIFO absorbing loader bytes while a RAM write is outstanding.
// A clear in the same cycle as a push leaves exactly that one entry.
module prg_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 9
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, wr_sel;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & (clr | ~full);
  assign do_pop  = pop & ~empty & ~clr;
  assign wr_sel  = clr ? '0 : wr_ptr;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_sel] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? nxt('0) : '0;
      count  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/prg_inject.sv
// Writes a PRG image from the loader byte stream into VIC-20 RAM, then patches BASIC pointers.
//   state  | meaning
//   IDLE   | waiting for a PRG download to start
//   HDR_LO | waiting for load-address low byte
//   HDR_HI | waiting for load-address high byte
//   DATA   | draining payload bytes into RAM
//   PTR    | writing end address into the 8 pointer bytes
//   DONE   | one-cycle completion pulse
import prg_inject_pkg::*;

module prg_inject #(
  parameter bit         PATCH_PTRS = 1'b1,
  parameter logic [7:0] PTR_BASE   = PTR_BASE_DEF,
  parameter logic [7:0] EAL_ADDR   = EAL_ADDR_DEF,
  parameter int         FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ioctl_download,
  input  logic        load_prg,
  input  logic [22:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic        ioctl_wait,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_we,
  input  logic        ram_ack,
  output logic [15:0] prg_start,
  output logic [15:0] prg_end,
  output logic        prg_busy,
  output logic        prg_done,
  output logic        prg_error
);

  localparam int       CW      = $clog2(FIFO_DEPTH + 1);
  localparam ptr_tbl_t PTR_TBL = ptr_table(PTR_BASE, EAL_ADDR);

  state_t        state, state_n;
  logic          act_q, start, push_ok;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [8:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [16:0]   wp, wp_n;
  logic [15:0]   start_n, end_n, addr_n;
  logic [7:0]    dout_n;
  logic [2:0]    ptr_cnt, cnt_n, ptr_idx;
  logic          we_n, err_n;

  assign start     = (state == IDLE) & ioctl_download & load_prg & ~act_q;
  assign push_ok   = ioctl_wr & ioctl_download & load_prg
                   & (start | (state inside {HDR_LO, HDR_HI, DATA}));
  assign fifo_push = push_ok & (start | ~fifo_full);
  assign ptr_idx   = 3'd7 - ptr_cnt;

  assign ioctl_wait = (fifo_count >= CW'(FIFO_DEPTH - 1)) | (state == PTR) | (state == DONE);
  assign prg_busy   = (state != IDLE);
  assign prg_done   = (state == DONE);

  prg_skid_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clr    (start),
    .push   (fifo_push),
    .din    ({ioctl_addr < 23'(HDR_BYTES), ioctl_data}),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    state_n  = state;
    start_n  = prg_start;
    end_n    = prg_end;
    wp_n     = wp;
    addr_n   = ram_addr;
    dout_n   = ram_dout;
    we_n     = ram_we;
    cnt_n    = ptr_cnt;
    err_n    = prg_error;
    fifo_pop = 1'b0;
    case (state)
      IDLE: if (start) begin
        start_n = '0;
        end_n   = '0;
        err_n   = 1'b0;
        wp_n    = '0;
        state_n = HDR_LO;
      end
      HDR_LO: if (!fifo_empty) begin
        fifo_pop     = 1'b1;
        start_n[7:0] = fifo_dout[7:0];
        state_n      = HDR_HI;
      end else if (!ioctl_download) begin
        err_n   = 1'b1;
        state_n = DONE;
      end
      HDR_HI: if (!fifo_empty) begin
        fifo_pop      = 1'b1;
        start_n[15:8] = fifo_dout[7:0];
        wp_n          = {1'b0, fifo_dout[7:0], prg_start[7:0]};
        state_n       = DATA;
      end else if (!ioctl_download) begin
        err_n   = 1'b1;
        state_n = DONE;
      end
      DATA: begin
        if (ram_we) begin
          if (ram_ack) begin
            fifo_pop = 1'b1;
            we_n     = 1'b0;
            wp_n     = wp + 17'd1;
          end
        end else if (!fifo_empty) begin
          // Stray header-tagged bytes and anything past 0xFFFF are dropped, not written.
          if (fifo_dout[8]) begin
            fifo_pop = 1'b1;
          end else if (wp[16]) begin
            fifo_pop = 1'b1;
            err_n    = 1'b1;
          end else begin
            addr_n = wp[15:0];
            dout_n = fifo_dout[7:0];
            we_n   = 1'b1;
          end
        end else if (!ioctl_download) begin
          end_n = wp[15:0];
          if (PATCH_PTRS && !prg_error) begin
            cnt_n   = 3'd7;
            state_n = PTR;
          end else begin
            state_n = DONE;
          end
        end
      end
      PTR: begin
        if (ram_we) begin
          if (ram_ack) begin
            we_n = 1'b0;
            if (ptr_cnt == 3'd0) state_n = DONE;
            else                 cnt_n   = ptr_cnt - 3'd1;
          end
        end else begin
          addr_n = {8'h00, PTR_TBL[ptr_idx]};
          dout_n = ptr_idx[0] ? prg_end[15:8] : prg_end[7:0];
          we_n   = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (push_ok && fifo_full && !start) err_n = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      act_q     <= 1'b0;
      prg_start <= '0;
      prg_end   <= '0;
      wp        <= '0;
      ram_addr  <= '0;
      ram_dout  <= '0;
      ram_we    <= 1'b0;
      ptr_cnt   <= '0;
      prg_error <= 1'b0;
    end else begin
      state     <= state_n;
      act_q     <= ioctl_download & load_prg;
      prg_start <= start_n;
      prg_end   <= end_n;
      wp        <= wp_n;
      ram_addr  <= addr_n;
      ram_dout  <= dout_n;
      ram_we    <= we_n;
      ptr_cnt   <= cnt_n;
      prg_error <= err_n;
    end
  end

endmodule

// File: tb/tb_prg_inject.sv
// Directed bench for prg_inject: loader model with one-cycle wait lag and a RAM responder.
module tb_prg_inject;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        load_prg = 1'b0;
  logic [22:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        ram_ack = 1'b0;
  logic        ioctl_wait, ram_we, prg_busy, prg_done, prg_error;
  logic [15:0] ram_addr, prg_start, prg_end;
  logic [7:0]  ram_dout;

  always #5 clk = ~clk;

  prg_inject dut (
    .clk            (clk),
    .resetn         (resetn),
    .ioctl_download (ioctl_download),
    .load_prg       (load_prg),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wr       (ioctl_wr),
    .ioctl_wait     (ioctl_wait),
    .ram_addr       (ram_addr),
    .ram_dout       (ram_dout),
    .ram_we         (ram_we),
    .ram_ack        (ram_ack),
    .prg_start      (prg_start),
    .prg_end        (prg_end),
    .prg_busy       (prg_busy),
    .prg_done       (prg_done),
    .prg_error      (prg_error)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  img[$];
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  int          done_cnt;
  bit          wait_seen, busy_seen, we_seen, loader_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reacts to ioctl_wait one cycle late, so one byte can still arrive after assertion.
  task automatic loader(input bit is_prg);
    bit lag = 1'b0;
    int idx = 0;
    int cyc = 0;
    @(negedge clk);
    ioctl_download = 1'b1;
    load_prg       = is_prg;
    while (idx < img.size() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!lag) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 23'(idx);
        ioctl_data = img[idx];
        idx++;
      end else begin
        ioctl_wr = 1'b0;
      end
      lag = ioctl_wait;
    end
    chk("loader_bytes_sent", 32'(idx), 32'(img.size()));
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
    ioctl_download = 1'b0;
    loader_done = 1'b1;
  endtask

  task automatic ram_side(input int delay, input bit expect_done);
    int wcnt  = 0;
    int cyc   = 0;
    int quiet = 0;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (prg_done)   done_cnt++;
      if (ioctl_wait) wait_seen = 1'b1;
      if (prg_busy)   busy_seen = 1'b1;
      if (ram_we)     we_seen = 1'b1;
      if (delay == 0) begin
        ram_ack = 1'b1;
        if (ram_we) begin
          log_addr.push_back(ram_addr);
          log_data.push_back(ram_dout);
        end
      end else if (ram_we) begin
        wcnt++;
        if (wcnt >= delay) begin
          ram_ack = 1'b1;
          log_addr.push_back(ram_addr);
          log_data.push_back(ram_dout);
          wcnt = 0;
        end else begin
          ram_ack = 1'b0;
        end
      end else begin
        ram_ack = 1'b0;
        wcnt    = 0;
      end
      if (loader_done) quiet++;
      if (loader_done && expect_done && done_cnt > 0 && !prg_done) break;
      if (loader_done && !expect_done && quiet > 40) break;
    end
    ram_ack = 1'b0;
    chk("run_within_budget", 32'(cyc < 4000), 32'd1);
  endtask

  task automatic run_load(input int delay, input bit is_prg, input bit expect_done);
    log_addr.delete();
    log_data.delete();
    done_cnt    = 0;
    wait_seen   = 1'b0;
    busy_seen   = 1'b0;
    we_seen     = 1'b0;
    loader_done = 1'b0;
    fork
      loader(is_prg);
      ram_side(delay, expect_done);
    join
  endtask

  task automatic check_std(input string pfx);
    logic [15:0] ea [11] = '{16'h1001, 16'h1002, 16'h1003, 16'h002D, 16'h002E, 16'h002F,
                             16'h0030, 16'h0031, 16'h0032, 16'h00AE, 16'h00AF};
    logic [7:0]  ed [11] = '{8'hAA, 8'hBB, 8'hCC, 8'h04, 8'h10, 8'h04,
                             8'h10, 8'h04, 8'h10, 8'h04, 8'h10};
    chk({pfx, "_nwr"}, 32'(log_addr.size()), 32'd11);
    for (int i = 0; i < 11 && i < log_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", pfx, i), 32'(log_addr[i]), 32'(ea[i]));
      chk($sformatf("%s_data%0d", pfx, i), 32'(log_data[i]), 32'(ed[i]));
    end
    chk({pfx, "_start"}, 32'(prg_start), 32'h1001);
    chk({pfx, "_end"},   32'(prg_end),   32'h1004);
    chk({pfx, "_error"}, 32'(prg_error), 32'd0);
    chk({pfx, "_done"},  32'(done_cnt),  32'd1);
    chk({pfx, "_idle"},  32'(prg_busy),  32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wait",  32'(ioctl_wait), 32'd0);
    chk("rst_we",    32'(ram_we),     32'd0);
    chk("rst_addr",  32'(ram_addr),   32'd0);
    chk("rst_busy",  32'(prg_busy),   32'd0);
    chk("rst_done",  32'(prg_done),   32'd0);
    chk("rst_error", 32'(prg_error),  32'd0);
    chk("rst_start", 32'(prg_start),  32'd0);
    chk("rst_end",   32'(prg_end),    32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Basic image, immediate acks
    img = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    run_load(0, 1'b1, 1'b1);
    check_std("t1");

    // Slow RAM: loader is held off and the in-flight byte must survive
    run_load(20, 1'b1, 1'b1);
    check_std("t2");
    chk("t2_wait_seen", 32'(wait_seen), 32'd1);

    // Address wrap past 0xFFFF
    img = '{8'hFE, 8'hFF, 8'h11, 8'h22, 8'h33};
    run_load(0, 1'b1, 1'b1);
    chk("t3_nwr", 32'(log_addr.size()), 32'd2);
    for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
      chk($sformatf("t3_addr%0d", i), 32'(log_addr[i]), 32'hFFFE + 32'(i));
      chk($sformatf("t3_data%0d", i), 32'(log_data[i]), 32'h11 * 32'(i + 1));
    end
    chk("t3_start", 32'(prg_start), 32'hFFFE);
    chk("t3_end",   32'(prg_end),   32'h0000);
    chk("t3_error", 32'(prg_error), 32'd1);
    chk("t3_done",  32'(done_cnt),  32'd1);

    // Truncated header
    img = '{8'h01};
    run_load(0, 1'b1, 1'b1);
    chk("t4_nwr",   32'(log_addr.size()), 32'd0);
    chk("t4_error", 32'(prg_error),       32'd1);
    chk("t4_done",  32'(done_cnt),        32'd1);

    // Non-PRG transfer is invisible
    img = '{8'h01, 8'h10, 8'hAA};
    run_load(0, 1'b0, 1'b0);
    chk("t5_we",   32'(we_seen),   32'd0);
    chk("t5_wait", 32'(wait_seen), 32'd0);
    chk("t5_busy", 32'(busy_seen), 32'd0);
    chk("t5_done", 32'(done_cnt),  32'd0);

    // Async reset while a RAM write is pending
    ram_ack = 1'b0;
    @(negedge clk);
    ioctl_download = 1'b1;
    load_prg       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ioctl_wr   = 1'b1;
      ioctl_addr = 23'(i);
      ioctl_data = img[i];
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    for (int k = 0; k < 10 && !ram_we; k++) @(negedge clk);
    chk("t6_we_pending", 32'(ram_we), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_we",    32'(ram_we),     32'd0);
    chk("t6_rst_addr",  32'(ram_addr),   32'd0);
    chk("t6_rst_dout",  32'(ram_dout),   32'd0);
    chk("t6_rst_wait",  32'(ioctl_wait), 32'd0);
    chk("t6_rst_busy",  32'(prg_busy),   32'd0);
    chk("t6_rst_start", 32'(prg_start),  32'd0);
    chk("t6_rst_done",  32'(prg_done),   32'd0);
    ioctl_download = 1'b0;
    load_prg       = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", 32'(prg_done), 32'd0);
    img = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    run_load(0, 1'b1, 1'b1);
    check_std("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
